// File: rtl/vga_capture_monitor.sv
// rtl/vga_capture_monitor.sv - TinyVGA receive-side timing checker with per-frame CRC
module vga_capture_monitor #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  input  logic        clear,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_crc,
  output logic [7:0]  frame_count,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam logic [11:0] H_TOTAL = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [11:0] V_TOTAL = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [11:0] H_SYNC_W = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_W = 12'(V_SYNC);
  localparam logic [11:0] H_START = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_END   = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_START = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_END   = 12'(V_SYNC + V_BP + V_ACTIVE);
  // Pin pattern with both syncs inactive, so reset does not fake a sync edge
  localparam logic [7:0]  IDLE_PINS = {~SYNC_POL, 3'b000, ~SYNC_POL, 3'b000};

  typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_LOCKED} state_t;

  state_t      state, state_nx;
  logic [7:0]  s1;
  logic        s2_hact;
  logic [11:0] hcnt, hcnt_nx, vcnt, vcnt_nx;
  logic        vs_prev, v_pending;
  logic        hs1, vs1, hle, hte, vle;
  logic        active, geo_hit, geo_err, frame_evt;
  logic [5:0]  rgb_s1;
  logic [15:0] crc_acc;

  // Byte-parallel CRC-16/CCITT-FALSE update (MSB first, poly 0x1021)
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  assign hs1    = (s1[7] == SYNC_POL);
  assign vs1    = (s1[3] == SYNC_POL);
  assign hle    = hs1 && !s2_hact;
  assign hte    = !hs1 && s2_hact;
  assign vle    = hle && vs1 && !vs_prev;
  assign rgb_s1 = {s1[0], s1[4], s1[1], s1[5], s1[2], s1[6]};
  assign locked = (state == S_LOCKED);

  // Position of the sample currently in s1; both counters stop at their totals
  always_comb begin
    hcnt_nx = hcnt;
    vcnt_nx = vcnt;
    if (hle)                  hcnt_nx = '0;
    else if (hcnt != H_TOTAL) hcnt_nx = hcnt + 12'd1;
    if (vle)                          vcnt_nx = '0;
    else if (hle && vcnt != V_TOTAL)  vcnt_nx = vcnt + 12'd1;
    active = (hcnt_nx >= H_START) && (hcnt_nx < H_END) &&
             (vcnt_nx >= V_START) && (vcnt_nx < V_END);
  end

  // Geometry violations; only acted on once the monitor has seen a frame start
  always_comb begin
    geo_hit = 1'b0;
    if (hle && hcnt != H_TOTAL - 12'd1)                geo_hit = 1'b1;
    if (!hle && hcnt == H_TOTAL - 12'd1)               geo_hit = 1'b1;
    if (hte && hcnt_nx != H_SYNC_W)                    geo_hit = 1'b1;
    if (vle && vcnt != V_TOTAL - 12'd1)                geo_hit = 1'b1;
    if (hle && !vle && vcnt == V_TOTAL - 12'd1)        geo_hit = 1'b1;
    if (hle && !vs1 && v_pending && vcnt_nx != V_SYNC_W) geo_hit = 1'b1;
    geo_err = geo_hit && (state != S_SEARCH) && !clear;
  end

  // Lock state machine: next state and frame-completion event
  always_comb begin
    state_nx  = state;
    frame_evt = 1'b0;
    case (state)
      S_SEARCH: if (vle) state_nx = S_TRACK;
      S_TRACK: begin
        if (geo_err) state_nx = S_SEARCH;
        else if (vle) begin
          state_nx  = S_LOCKED;
          frame_evt = 1'b1;
        end
      end
      S_LOCKED: begin
        if (geo_err)  state_nx = S_SEARCH;
        else if (vle) frame_evt = 1'b1;
      end
      default: state_nx = S_SEARCH;
    endcase
    if (clear) begin
      state_nx  = S_SEARCH;
      frame_evt = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_SEARCH;
    else        state <= state_nx;
  end

  // Input pipeline and sync timing recovery; keeps running through clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= IDLE_PINS;
      s2_hact   <= 1'b0;
      hcnt      <= '0;
      vcnt      <= '0;
      vs_prev   <= 1'b0;
      v_pending <= 1'b0;
    end else begin
      s1      <= vga_in;
      s2_hact <= hs1;
      hcnt    <= hcnt_nx;
      vcnt    <= vcnt_nx;
      if (hle) vs_prev <= vs1;
      if (vle)              v_pending <= 1'b1;
      else if (hle && !vs1) v_pending <= 1'b0;
    end
  end

  // Pixel outputs, CRC accumulation, frame and error reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_done  <= 1'b0;
      frame_crc   <= 16'h0000;
      frame_count <= '0;
      err         <= 1'b0;
      err_count   <= '0;
      crc_acc     <= 16'hFFFF;
    end else if (clear) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      err         <= 1'b0;
      err_count   <= '0;
      crc_acc     <= 16'hFFFF;
    end else begin
      pix_valid  <= active;
      pix_x      <= active ? 10'(hcnt_nx - H_START) : '0;
      pix_y      <= active ? 10'(vcnt_nx - V_START) : '0;
      pix_rgb    <= active ? rgb_s1 : '0;
      frame_done <= frame_evt;
      err        <= geo_err;
      if (geo_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (frame_evt) begin
        frame_crc   <= crc_acc;
        frame_count <= frame_count + 8'd1;
      end
      if (vle)         crc_acc <= 16'hFFFF;
      else if (active) crc_acc <= crc16_step(crc_acc, {2'b00, rgb_s1});
    end
  end

endmodule

// File: tb/tb_vga_capture_monitor.sv
// tb/tb_vga_capture_monitor.sv - directed self-checking bench for vga_capture_monitor
`timescale 1ns/1ps
module tb_vga_capture_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] vga_a = 8'h88, vga_b = 8'h88, vga_c = 8'h88;

  logic a_locked, a_pix_valid, a_frame_done, a_err;
  logic [9:0] a_pix_x, a_pix_y;
  logic [5:0] a_pix_rgb;
  logic [15:0] a_frame_crc;
  logic [7:0] a_frame_count, a_err_count;

  logic b_locked, b_pix_valid, b_frame_done, b_err;
  logic [9:0] b_pix_x, b_pix_y;
  logic [5:0] b_pix_rgb;
  logic [15:0] b_frame_crc;
  logic [7:0] b_frame_count, b_err_count;

  logic c_locked, c_pix_valid, c_frame_done, c_err;
  logic [9:0] c_pix_x, c_pix_y;
  logic [5:0] c_pix_rgb;
  logic [15:0] c_frame_crc;
  logic [7:0] c_frame_count, c_err_count;

  vga_capture_monitor #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_a), .clear(clear), .locked(a_locked),
    .pix_valid(a_pix_valid), .pix_x(a_pix_x), .pix_y(a_pix_y), .pix_rgb(a_pix_rgb),
    .frame_done(a_frame_done), .frame_crc(a_frame_crc), .frame_count(a_frame_count),
    .err(a_err), .err_count(a_err_count));

  vga_capture_monitor #(.H_ACTIVE(9), .H_FP(1), .H_SYNC(2), .H_BP(1),
                        .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_b), .clear(clear), .locked(b_locked),
    .pix_valid(b_pix_valid), .pix_x(b_pix_x), .pix_y(b_pix_y), .pix_rgb(b_pix_rgb),
    .frame_done(b_frame_done), .frame_crc(b_frame_crc), .frame_count(b_frame_count),
    .err(b_err), .err_count(b_err_count));

  vga_capture_monitor #(.H_ACTIVE(1), .H_FP(1), .H_SYNC(2), .H_BP(1),
                        .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_c), .clear(clear), .locked(c_locked),
    .pix_valid(c_pix_valid), .pix_x(c_pix_x), .pix_y(c_pix_y), .pix_rgb(c_pix_rgb),
    .frame_done(c_frame_done), .frame_crc(c_frame_crc), .frame_count(c_frame_count),
    .err(c_err), .err_count(c_err_count));

  int errors = 0;
  int checks = 0;

  logic [25:0] sb_q[$];
  int  sb_bad = 0, pix_cnt_a = 0, fd_cnt_a = 0, err_pulse_a = 0;
  bit  seen_pix = 0, pix_drv_seen = 0;
  time t_pix_seen, t_pix_drv, t_fd, t_vle_drv, t_err, t_nosync_drv;
  logic [15:0] crc_a;

  function automatic logic [7:0] enc(input logic [5:0] c);
    logic [7:0] p;
    p = '0;
    p[0] = c[5]; p[4] = c[4]; p[1] = c[3]; p[5] = c[2]; p[2] = c[1]; p[6] = c[0];
    return p;
  endfunction

  function automatic logic [5:0] pat_a(input int x, input int y);
    return 6'(x * 5 + y * 9 + 3);
  endfunction

  function automatic logic [15:0] ref_crc(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] r;
    r = crc;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = (r << 1) ^ 16'h1021;
      else              r = r << 1;
    end
    return r;
  endfunction

  // Observe dut_a outputs away from the rising edge; scoreboard active pixels
  always @(negedge clk) begin
    logic [25:0] e;
    if (a_pix_valid) begin
      pix_cnt_a++;
      if (!seen_pix) begin seen_pix = 1; t_pix_seen = $time; end
      if (sb_q.size() == 0) sb_bad++;
      else begin
        e = sb_q.pop_front();
        if ({a_pix_y, a_pix_x, a_pix_rgb} !== e) sb_bad++;
      end
    end
    if (a_frame_done) begin fd_cnt_a++; t_fd = $time; end
    if (a_err) begin err_pulse_a++; t_err = $time; end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vga_a = 8'h88; vga_b = 8'h88; vga_c = 8'h88;
    end
  endtask

  task automatic drive_frame(input int sel, input int ha, input int hf, input int hs, input int hb,
                             input int va, input int vf, input int vs, input int vb,
                             input int short_line, input int nosync_line);
    int ht, vt, x, y;
    logic [7:0] px;
    logic [5:0] rgb;
    bit act;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    for (int v = 0; v < vt; v++) begin
      for (int h = 0; h < ht; h++) begin
        if (v == short_line && h == ht - 1) continue;
        px = 8'h88;
        rgb = '0;
        if (h < hs && v != nosync_line) px[7] = 1'b0;
        if (v < vs) px[3] = 1'b0;
        act = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
        x = h - hs - hb;
        y = v - vs - vb;
        if (act) begin
          case (sel)
            0:       rgb = pat_a(x, y);
            1:       rgb = 6'(8'h31 + x);
            default: rgb = 6'h00;
          endcase
          px = px | enc(rgb);
        end
        @(negedge clk);
        case (sel)
          0:       vga_a = px;
          1:       vga_b = px;
          default: vga_c = px;
        endcase
        if (sel == 0) begin
          if (v == 0 && h == 0) t_vle_drv = $time;
          if (v == nosync_line && h == 0) t_nosync_drv = $time;
          if (act) begin
            sb_q.push_back({10'(y), 10'(x), rgb});
            if (!pix_drv_seen) begin pix_drv_seen = 1; t_pix_drv = $time; end
          end
        end
      end
    end
  endtask

  task automatic frame_a(input int short_line, input int nosync_line);
    drive_frame(0, 8, 2, 3, 2, 6, 1, 2, 2, short_line, nosync_line);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(20);
    checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", a_locked); end
    checks++; if ({a_pix_valid, a_pix_x, a_pix_y, a_pix_rgb} !== 27'd0) begin errors++;
      $display("FAIL reset_pix: got %0h want 0", {a_pix_valid, a_pix_x, a_pix_y, a_pix_rgb}); end
    checks++; if ({a_frame_done, a_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %0b want 00", {a_frame_done, a_err}); end
    checks++; if (a_frame_crc !== 16'h0000) begin errors++; $display("FAIL reset_crc: got %h want 0000", a_frame_crc); end
    checks++; if ({a_frame_count, a_err_count} !== 16'h0000) begin errors++;
      $display("FAIL reset_counts: got %h want 0000", {a_frame_count, a_err_count}); end
    rst_n = 1'b1;
    idle(5);
    checks++; if ({a_locked, a_err, b_locked, c_locked} !== 4'b0000) begin errors++;
      $display("FAIL post_reset_idle: got %b want 0000", {a_locked, a_err, b_locked, c_locked}); end
  endtask

  task automatic test_crc_vectors;
    for (int f = 0; f < 3; f++) drive_frame(1, 9, 1, 2, 1, 1, 1, 1, 1, -1, -1);
    checks++; if (b_frame_crc !== 16'h29B1) begin errors++; $display("FAIL crc_123456789: got %h want 29b1", b_frame_crc); end
    checks++; if (b_frame_count !== 8'd2) begin errors++; $display("FAIL crc_b_count: got %0d want 2", b_frame_count); end
    checks++; if ({b_locked, b_err_count} !== {1'b1, 8'd0}) begin errors++;
      $display("FAIL crc_b_lock: got %b/%0d want 1/0", b_locked, b_err_count); end
    for (int f = 0; f < 3; f++) drive_frame(2, 1, 1, 2, 1, 1, 1, 1, 1, -1, -1);
    checks++; if (c_frame_crc !== 16'hE1F0) begin errors++; $display("FAIL crc_single_zero: got %h want e1f0", c_frame_crc); end
    checks++; if (c_frame_count !== 8'd2) begin errors++; $display("FAIL crc_c_count: got %0d want 2", c_frame_count); end
  endtask

  task automatic test_lock_sequence;
    crc_a = 16'hFFFF;
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++) crc_a = ref_crc(crc_a, {2'b00, pat_a(x, y)});
    frame_a(-1, -1);
    checks++; if ({a_locked, 8'(fd_cnt_a)} !== {1'b0, 8'd0}) begin errors++;
      $display("FAIL track_frame1: locked/fd got %b/%0d want 0/0", a_locked, fd_cnt_a); end
    frame_a(-1, -1);
    checks++; if ({a_locked, 8'(fd_cnt_a)} !== {1'b1, 8'd1}) begin errors++;
      $display("FAIL lock_frame2: locked/fd got %b/%0d want 1/1", a_locked, fd_cnt_a); end
    checks++; if (a_frame_count !== 8'd1) begin errors++; $display("FAIL lock_count1: got %0d want 1", a_frame_count); end
    checks++; if (a_frame_crc !== crc_a) begin errors++; $display("FAIL lock_crc: got %h want %h", a_frame_crc, crc_a); end
    checks++; if (t_fd - t_vle_drv !== 20) begin errors++; $display("FAIL fd_latency: got %0t want 20", t_fd - t_vle_drv); end
    frame_a(-1, -1);
    checks++; if (a_frame_count !== 8'd2) begin errors++; $display("FAIL lock_count2: got %0d want 2", a_frame_count); end
    checks++; if (pix_cnt_a !== 144) begin errors++; $display("FAIL pix_count: got %0d want 144", pix_cnt_a); end
    checks++; if (sb_bad !== 0 || sb_q.size() !== 0) begin errors++;
      $display("FAIL pix_scoreboard: bad %0d left %0d want 0/0", sb_bad, sb_q.size()); end
    checks++; if (t_pix_seen - t_pix_drv !== 20) begin errors++; $display("FAIL pix_latency: got %0t want 20", t_pix_seen - t_pix_drv); end
    checks++; if ({a_err_count, 8'(err_pulse_a)} !== 16'h0000) begin errors++;
      $display("FAIL clean_no_err: got %0d/%0d want 0/0", a_err_count, err_pulse_a); end
  endtask

  task automatic test_short_line;
    frame_a(5, -1);
    checks++; if (err_pulse_a !== 1) begin errors++; $display("FAIL short_err_pulse: got %0d want 1", err_pulse_a); end
    checks++; if (a_err_count !== 8'd1) begin errors++; $display("FAIL short_err_count: got %0d want 1", a_err_count); end
    checks++; if ({a_locked, a_frame_count} !== {1'b0, 8'd3}) begin errors++;
      $display("FAIL short_unlock: locked/count got %b/%0d want 0/3", a_locked, a_frame_count); end
    frame_a(-1, -1);
    checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL relock_track: got %b want 0", a_locked); end
    frame_a(-1, -1);
    checks++; if ({a_locked, a_frame_count} !== {1'b1, 8'd4}) begin errors++;
      $display("FAIL relock: locked/count got %b/%0d want 1/4", a_locked, a_frame_count); end
    checks++; if (err_pulse_a !== 1) begin errors++; $display("FAIL relock_no_err: got %0d want 1", err_pulse_a); end
  endtask

  task automatic test_missing_hsync_clear;
    frame_a(-1, 10);
    checks++; if ({8'(err_pulse_a), a_err_count} !== {8'd2, 8'd2}) begin errors++;
      $display("FAIL nosync_err: pulses/count got %0d/%0d want 2/2", err_pulse_a, a_err_count); end
    checks++; if (t_err - t_nosync_drv !== 20) begin errors++; $display("FAIL err_latency: got %0t want 20", t_err - t_nosync_drv); end
    checks++; if ({a_locked, a_frame_count} !== {1'b0, 8'd5}) begin errors++;
      $display("FAIL nosync_state: locked/count got %b/%0d want 0/5", a_locked, a_frame_count); end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    idle(1);
    checks++; if ({a_err_count, a_frame_count} !== 16'h0000) begin errors++;
      $display("FAIL clear_counts: got %0d/%0d want 0/0", a_err_count, a_frame_count); end
    checks++; if (a_frame_crc !== crc_a) begin errors++; $display("FAIL clear_keeps_crc: got %h want %h", a_frame_crc, crc_a); end
    checks++; if ({a_locked, a_err, a_frame_done} !== 3'b000) begin errors++;
      $display("FAIL clear_state: got %b want 000", {a_locked, a_err, a_frame_done}); end
  endtask

  initial begin
    test_reset();
    test_crc_vectors();
    test_lock_sequence();
    test_short_line();
    test_missing_hsync_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
